// File: rtl/mem_port_arbiter.sv
// Arbitrates one external memory bus between instruction fetch and EX-stage data
// requests, with per-requester acks, a pipeline stall and a sticky bus timeout flag.
module mem_port_arbiter #(
   parameter int          TIMEOUT  = 255,
   parameter int          CNT_W    = 8,
   parameter logic [31:0] ERR_DATA = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_req,
   input  logic [31:0] i_addr,
   output logic [31:0] i_rdata,
   output logic        i_ack,
   input  logic        d_req,
   input  logic        d_wen,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   output logic [31:0] d_rdata,
   output logic        d_ack,
   output logic        bus_req,
   output logic        bus_wen,
   output logic [31:0] bus_addr,
   output logic [31:0] bus_wdata,
   input  logic [31:0] bus_rdata,
   input  logic        bus_ack,
   output logic        stall,
   output logic        bus_err
);

   typedef enum logic [1:0] {IDLE, IBUSY, DBUSY} state_t;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic             i_elig;
   logic             d_elig;
   logic             timeout_hit;

   // A requester whose ack is showing this cycle has already been served.
   assign i_elig      = i_req & ~i_ack;
   assign d_elig      = d_req & ~d_ack;
   assign stall       = i_elig | d_elig;
   assign timeout_hit = (cnt == CNT_LAST);

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= '0;
         bus_req   <= 1'b0;
         bus_wen   <= 1'b0;
         bus_addr  <= 32'h0;
         bus_wdata <= 32'h0;
         i_ack     <= 1'b0;
         d_ack     <= 1'b0;
         i_rdata   <= 32'h0;
         d_rdata   <= 32'h0;
         bus_err   <= 1'b0;
      end else begin
         i_ack <= 1'b0;
         d_ack <= 1'b0;
         case (state)
            IDLE: begin
               if (d_elig) begin
                  bus_addr  <= d_addr;
                  bus_wen   <= d_wen;
                  bus_wdata <= d_wdata;
                  bus_req   <= 1'b1;
                  cnt       <= '0;
                  state     <= DBUSY;
               end else if (i_elig) begin
                  bus_addr  <= i_addr;
                  bus_wen   <= 1'b0;
                  bus_wdata <= 32'h0;
                  bus_req   <= 1'b1;
                  cnt       <= '0;
                  state     <= IBUSY;
               end
            end
            IBUSY, DBUSY: begin
               if (bus_ack) begin
                  bus_req <= 1'b0;
                  state   <= IDLE;
                  if (state == IBUSY) begin
                     i_ack   <= 1'b1;
                     i_rdata <= bus_rdata;
                  end else begin
                     d_ack   <= 1'b1;
                     d_rdata <= bus_wen ? 32'h0 : bus_rdata;
                  end
               end else if (timeout_hit) begin
                  // Abort: complete the owner with error data so it never hangs.
                  bus_req <= 1'b0;
                  bus_err <= 1'b1;
                  state   <= IDLE;
                  if (state == IBUSY) begin
                     i_ack   <= 1'b1;
                     i_rdata <= ERR_DATA;
                  end else begin
                     d_ack   <= 1'b1;
                     d_rdata <= ERR_DATA;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter: random requesters and bus responder feed
// per-requester expected-data queues that a separate monitor drains on each ack.
module tb_mem_port_arbiter;

   localparam int          TO       = 4;
   localparam logic [31:0] ERR      = 32'hDEAD_BEEF;
   localparam int          GEN_CYC  = 3000;
   localparam int          MAX_CYC  = 3400;

   logic        clk = 1'b0;
   logic        rst;
   logic        i_req, d_req, d_wen, bus_ack;
   logic [31:0] i_addr, d_addr, d_wdata, bus_rdata;
   logic [31:0] i_rdata, d_rdata, bus_addr, bus_wdata;
   logic        i_ack, d_ack, bus_req, bus_wen, stall, bus_err;

   int          n_cmp = 0;
   int          n_bad = 0;
   logic [31:0] i_exp_q[$];
   logic [31:0] d_exp_q[$];
   bit          mon_en = 1'b0;

   mem_port_arbiter #(.TIMEOUT(TO), .CNT_W(8), .ERR_DATA(ERR)) dut (
      .clk(clk), .rst(rst),
      .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack),
      .d_req(d_req), .d_wen(d_wen), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_rdata(d_rdata), .d_ack(d_ack),
      .bus_req(bus_req), .bus_wen(bus_wen), .bus_addr(bus_addr),
      .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack),
      .stall(stall), .bus_err(bus_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: pops expected read data whenever an ack is presented.
   initial begin
      logic [31:0] last_i, last_d;
      last_i = 32'h0;
      last_d = 32'h0;
      forever begin
         @(negedge clk);
         if (mon_en) begin
            if (i_ack) begin
               if (i_exp_q.size() == 0) begin
                  n_cmp++; n_bad++;
                  $display("FAIL i_ack_unexpected: got i_ack=1, required no ack (t=%0t)", $time);
               end else check("i_rdata", i_rdata, i_exp_q.pop_front());
               last_i = i_rdata;
            end else check("i_rdata_hold", i_rdata, last_i);
            if (d_ack) begin
               if (d_exp_q.size() == 0) begin
                  n_cmp++; n_bad++;
                  $display("FAIL d_ack_unexpected: got d_ack=1, required no ack (t=%0t)", $time);
               end else check("d_rdata", d_rdata, d_exp_q.pop_front());
               last_d = d_rdata;
            end else check("d_rdata_hold", d_rdata, last_d);
            check("stall", 32'(stall), 32'((i_req & ~i_ack) | (d_req & ~d_ack)));
         end
      end
   end

   // Stimulus: requesters, bus responder, grant/priority and timeout model.
   initial begin
      logic        br, ia, da, prev_br, prev_ia, prev_da;
      logic        ack_prev, abort_prev, ack_now, abort_now, spur;
      logic        de, ie, owner_d, exp_err, gen, drained;
      logic [31:0] rd;
      int          hi, k_target;

      rst = 1'b1; i_req = 1'b0; d_req = 1'b0; d_wen = 1'b0; bus_ack = 1'b0;
      i_addr = 32'h0; d_addr = 32'h0; d_wdata = 32'h0; bus_rdata = 32'h0;
      repeat (3) @(negedge clk);
      check("rst_bus_req", 32'(bus_req), 32'h0);
      check("rst_bus_err", 32'(bus_err), 32'h0);
      check("rst_acks", 32'({i_ack, d_ack, bus_wen}), 32'h0);
      check("rst_bus_addr", bus_addr, 32'h0);
      check("rst_i_rdata", i_rdata, 32'h0);
      check("rst_d_rdata", d_rdata, 32'h0);
      #1 rst = 1'b0;
      mon_en = 1'b1;

      prev_br = 1'b0; prev_ia = 1'b0; prev_da = 1'b0;
      ack_prev = 1'b0; abort_prev = 1'b0; exp_err = 1'b0;
      owner_d = 1'b0; hi = 0; k_target = 1; rd = 32'h0; drained = 1'b0;

      for (int cyc = 0; cyc < MAX_CYC; cyc++) begin
         @(negedge clk);
         gen = (cyc < GEN_CYC);
         br = bus_req; ia = i_ack; da = d_ack;

         if (abort_prev) exp_err = 1'b1;
         check("bus_err", 32'(bus_err), 32'(exp_err));

         if (!prev_br) begin
            // DUT was idle at the last edge: apply the grant rule.
            de = d_req & ~prev_da;
            ie = i_req & ~prev_ia;
            check("grant", 32'(br), 32'(de | ie));
            if (br) begin
               owner_d = de;
               hi = 0;
               k_target = $urandom_range(1, 6);
               check("bus_addr", bus_addr, de ? d_addr : i_addr);
               check("bus_wen", 32'(bus_wen), de ? 32'(d_wen) : 32'h0);
               check("bus_wdata", bus_wdata, de ? d_wdata : 32'h0);
            end
         end else begin
            check("bus_req_len", 32'(br), (ack_prev || abort_prev) ? 32'h0 : 32'h1);
         end

         ack_now = 1'b0; abort_now = 1'b0; spur = 1'b0;
         if (br && !ack_prev && !abort_prev) begin
            hi++;
            if (hi == k_target && k_target <= TO) begin
               ack_now = 1'b1;
               rd = $urandom;
               if (owner_d) d_exp_q.push_back(d_wen ? 32'h0 : rd);
               else         i_exp_q.push_back(rd);
            end else if (hi == TO) begin
               abort_now = 1'b1;
               if (owner_d) d_exp_q.push_back(ERR);
               else         i_exp_q.push_back(ERR);
            end
         end else if (!br && gen && $urandom_range(0, 7) == 0) begin
            spur = 1'b1;
         end

         if (!gen && !i_req && !d_req && !br && !ia && !da && !ack_prev && !abort_prev) begin
            drained = 1'b1;
            break;
         end

         #1;
         bus_ack   = ack_now | spur;
         bus_rdata = ack_now ? rd : $urandom;
         if (!i_req) begin
            if (gen && $urandom_range(0, 2) == 0) begin
               i_req  = 1'b1;
               i_addr = {1'b0, 29'($urandom), 2'b00};
            end
         end else if (ia) begin
            if (gen && $urandom_range(0, 1) == 0) i_addr = {1'b0, 29'($urandom), 2'b00};
            else i_req = 1'b0;
         end
         if (!d_req) begin
            if (gen && $urandom_range(0, 2) == 0) begin
               d_req   = 1'b1;
               d_wen   = 1'($urandom);
               d_addr  = {1'b1, 29'($urandom), 2'b00};
               d_wdata = $urandom;
            end
         end else if (da) begin
            if (gen && $urandom_range(0, 1) == 0) begin
               d_wen   = 1'($urandom);
               d_addr  = {1'b1, 29'($urandom), 2'b00};
               d_wdata = $urandom;
            end else d_req = 1'b0;
         end

         prev_br = br; prev_ia = ia; prev_da = da;
         ack_prev = ack_now; abort_prev = abort_now;
      end

      check("drained", 32'(drained), 32'h1);
      #1 bus_ack = 1'b0;
      @(negedge clk);
      check("i_q_empty", 32'(i_exp_q.size()), 32'h0);
      check("d_q_empty", 32'(d_exp_q.size()), 32'h0);
      mon_en = 1'b0;

      // Reset while a store owns the bus, then a late ack that must be ignored.
      #1;
      d_req = 1'b1; d_wen = 1'b1; d_addr = 32'h8000_0200; d_wdata = 32'h1234_5678;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         if (bus_req) break;
      end
      check("rt_bus_req", 32'(bus_req), 32'h1);
      check("rt_bus_addr", bus_addr, 32'h8000_0200);
      check("rt_bus_wdata", bus_wdata, 32'h1234_5678);
      #1 rst = 1'b1;
      @(negedge clk);
      check("rt_bus_req_rst", 32'(bus_req), 32'h0);
      check("rt_d_ack_rst", 32'(d_ack), 32'h0);
      check("rt_bus_err_rst", 32'(bus_err), 32'h0);
      check("rt_outs_rst", 32'({bus_wen, i_ack}), 32'h0);
      check("rt_bus_addr_rst", bus_addr, 32'h0);
      check("rt_d_rdata_rst", d_rdata, 32'h0);
      #1;
      rst = 1'b0; d_req = 1'b0; bus_ack = 1'b1; bus_rdata = 32'hCAFE_F00D;
      @(negedge clk);
      #1 bus_ack = 1'b0;
      @(negedge clk);
      check("late_ack_d_ack", 32'(d_ack), 32'h0);
      check("late_ack_bus_err", 32'(bus_err), 32'h0);
      check("late_ack_bus_req", 32'(bus_req), 32'h0);
      check("late_ack_d_rdata", d_rdata, 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single external memory bus between the instruction-fetch requester and the EX-stage data requester (load/store address and write data). Arbitrates pending requests and drives the bus through a req/ack handshake. Returns read data and one-cycle acknowledges to each requester, generates the pipeline stall, and aborts bus transactions that exceed a timeout.

## Interface
- TIMEOUT, 255: maximum cycles `bus_req` stays high without `bus_ack` before the transaction is aborted; legal range 1..2^CNT_W-1.
- CNT_W, 8: width of the timeout counter.
- ERR_DATA, 32'h0000_0000: read data returned on an aborted transaction.

- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- i_req  in  1  fetch request (read only); held high until `i_ack`.
- i_addr  in  32  fetch address; stable while `i_req` is high.
- i_rdata  out  32  fetch read data; valid when `i_ack`=1.
- i_ack  out  1  one-cycle fetch completion pulse.
- d_req  in  1  data request; held high until `d_ack`.
- d_wen  in  1  1 = store, 0 = load.
- d_addr  in  32  data address.
- d_wdata  in  32  store data.
- d_rdata  out  32  load data; valid when `d_ack`=1.
- d_ack  out  1  one-cycle data completion pulse.
- bus_req  out  1  bus transaction request.
- bus_wen  out  1  bus write enable.
- bus_addr  out  32  bus address.
- bus_wdata  out  32  bus write data.
- bus_rdata  in  32  bus read data; valid with `bus_ack`.
- bus_ack  in  1  bus completion, one cycle per transaction.
- stall  out  1  pipeline stall, combinational.
- bus_err  out  1  sticky timeout flag; cleared only by `rst`.

## Operation
- FSM states: IDLE, IBUSY, DBUSY.
- IDLE:
  - Eligible requests: `i_req & ~i_ack` and `d_req & ~d_ack`. The requester being acknowledged this cycle is ignored.
  - Data wins when both are eligible.
  - On a grant, register `bus_addr`/`bus_wen`/`bus_wdata` from the winner. Fetch grants force `bus_wen`=0 and `bus_wdata`=0.
  - Set `bus_req`=1, clear the counter, go to IBUSY or DBUSY.
- IBUSY/DBUSY:
  - Hold all bus outputs. Counter increments each cycle `bus_ack`=0.
  - On `bus_ack`=1:
    - Next cycle: `bus_req`=0, state IDLE.
    - The owner's `x_ack` pulses 1 for one cycle with `x_rdata` = `bus_rdata` captured at the ack edge.
    - Store completions return `d_rdata` = 0.
  - On counter == TIMEOUT-1 with `bus_ack`=0:
    - Abort: `bus_req`=0, state IDLE.
    - The owner's `x_ack` pulses with `x_rdata` = ERR_DATA.
    - `bus_err` goes to 1.
- `bus_ack` received in IDLE is ignored and does not set `bus_err`.
- `x_rdata` holds its last value between acks.
- stall = (`i_req` & ~`i_ack`) | (`d_req` & ~`d_ack`).
- Reset: state IDLE; `bus_req`, `bus_wen`, `i_ack`, `d_ack`, `bus_err` = 0; `bus_addr`, `bus_wdata`, `i_rdata`, `d_rdata` = 0; counter = 0.
- Reset mid-transaction:
  - Abandons the transaction with no ack to the requester.
  - `bus_req` drops the cycle after `rst` is sampled high.

## Timing
- Request sampled in IDLE at edge N. `bus_req` is high from cycle N+1.
- `bus_ack` sampled at edge M (M ≥ N+1). `x_ack` is high in cycle M+1, and the FSM is IDLE in cycle M+1.
- A new grant can be made at edge M+1, so `bus_req` is high again in cycle M+2. Minimum transaction is 3 cycles request-to-ack; back-to-back spacing is 2 cycles.
- Timeout: with no ack, `bus_req` is high for exactly TIMEOUT cycles, and `x_ack` follows in the next cycle.
- Counter compare is unsigned CNT_W-bit and never wraps; saturation is not reachable.

## Test plan
- Single load:
  - Stimulus: `d_req`=1, `d_wen`=0, `d_addr`=0x100; bus acks 2 cycles after `bus_req` with `bus_rdata`=0xCAFEF00D.
  - Required: `bus_addr`=0x100 and `bus_wen`=0; `d_ack` one cycle with `d_rdata`=0xCAFEF00D; `stall`=1 until the `d_ack` cycle.
- Simultaneous requests:
  - Stimulus: `i_req` (0x0) and `d_req` store (0x200, data 0x12345678) in the same cycle.
  - Required: the store is issued first with `bus_wen`=1 and `bus_wdata`=0x12345678. The fetch is issued with `bus_req` high 1 cycle after the `d_ack` cycle, and `i_ack` follows its bus ack.
- Back-to-back fetches:
  - Stimulus: `i_req` stays high across the ack with a new address 0x4; bus acks immediately.
  - Required: no duplicate grant in the ack cycle; second `bus_req` for 0x4 starts at M+2.
- Timeout:
  - Stimulus: TIMEOUT=4, fetch to 0x8, bus never acks.
  - Required: `bus_req` high exactly 4 cycles; `i_ack` with `i_rdata`=ERR_DATA; `bus_err`=1 and stays 1 through later successful transactions.
- Reset mid-transaction:
  - Stimulus: assert `rst` while in DBUSY.
  - Required: next cycle `bus_req`=0, `d_ack`=0, `bus_err`=0, all outputs at reset values; a late `bus_ack` is ignored.
